// File: rtl/lcd_pkg.sv
// Shared constants for the 16x2 LCD sequencer: state codes, HD44780 command bytes and
// step-to-byte/address helpers.
package lcd_pkg;

    localparam logic [2:0] ST_PWRUP = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_IDLE  = 3'd4;

    localparam logic MODE_INIT    = 1'b0;
    localparam logic MODE_REFRESH = 1'b1;

    localparam int unsigned LCD_CHARS = 32;

    localparam logic [5:0] INIT_LAST_STEP    = 6'd3;
    localparam logic [5:0] REFRESH_LAST_STEP = 6'd33;
    localparam logic [5:0] LINE2_STEP        = 6'd17;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    function automatic logic [7:0] init_byte(input logic [5:0] step);
        logic [7:0] b;
        case (step[1:0])
            2'd0:    b = CMD_FUNC_SET;
            2'd1:    b = CMD_DISP_ON;
            2'd2:    b = CMD_CLEAR;
            default: b = CMD_ENTRY;
        endcase
        return b;
    endfunction

    // Steps 1-16 map to line 1 chars 0-15, steps 18-33 to line 2 chars 16-31.
    function automatic logic [4:0] refresh_addr(input logic [5:0] step);
        logic [5:0] a;
        a = 6'd0;
        if (step >= 6'd1 && step <= 6'd16) begin
            a = step - 6'd1;
        end else if (step >= 6'd18 && step <= 6'd33) begin
            a = step - 6'd2;
        end
        return a[4:0];
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Saturating cycle counter with synchronous clear and terminal-count compare against a
// runtime limit; a limit of N gives an N-cycle wait.
module lcd_delay_counter #(
    parameter int unsigned WIDTH = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_last;

    assign w_last = (i_limit == '0) ? '0 : i_limit - WIDTH'(1);
    assign o_tc   = (r_count == w_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (r_count != '1) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/lcd_sequencer.sv
// Drives the single-byte LCD writer: power-up wait, HD44780 init sequence, then full
// two-line refreshes from the character buffer on request.
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter logic [19:0] POWERUP_CYC = 20'd750000,
    parameter logic [19:0] GAP_CYC     = 20'd2500,
    parameter logic [19:0] CLR_CYC     = 20'd100000,
    parameter logic [19:0] TIMEOUT_CYC = 20'd1000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_refresh_req,
    output logic [4:0] o_char_addr,
    input  logic [7:0] i_char_data,
    output logic [7:0] o_wr_data,
    output logic       o_wr_rs,
    output logic       o_wr_start,
    input  logic       i_wr_done,
    output logic       o_init_done,
    output logic       o_busy,
    output logic       o_err
);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic        r_mode;
    logic        w_mode_nxt;
    logic [5:0]  r_step;
    logic [5:0]  w_step_nxt;
    logic        r_pending;
    logic        w_pending_nxt;
    logic        r_init_done;
    logic        w_init_done_nxt;
    logic        r_err;
    logic        w_err_nxt;
    logic [7:0]  r_wr_data;
    logic [7:0]  w_wr_data_nxt;
    logic        r_wr_rs;
    logic        w_wr_rs_nxt;
    logic        r_wr_start;
    logic        w_wr_start_nxt;

    logic [19:0] w_limit;
    logic        w_tc;
    logic        w_cnt_clear;
    logic        w_last_step;
    logic        w_is_clear;

    assign w_last_step = (r_mode == MODE_INIT) ? (r_step == INIT_LAST_STEP)
                                               : (r_step == REFRESH_LAST_STEP);
    assign w_is_clear  = !r_wr_rs && (r_wr_data == CMD_CLEAR);
    assign w_cnt_clear = (w_state_nxt != r_state);

    always_comb begin
        case (r_state)
            ST_PWRUP: w_limit = POWERUP_CYC;
            ST_WAIT:  w_limit = TIMEOUT_CYC;
            ST_GAP:   w_limit = w_is_clear ? CLR_CYC : GAP_CYC;
            default:  w_limit = GAP_CYC;
        endcase
    end

    lcd_delay_counter #(
        .WIDTH (20)
    ) u_delay (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (w_cnt_clear),
        .i_limit (w_limit),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_mode_nxt      = r_mode;
        w_step_nxt      = r_step;
        w_pending_nxt   = r_pending | i_refresh_req;
        w_init_done_nxt = r_init_done;
        w_err_nxt       = r_err;
        w_wr_data_nxt   = r_wr_data;
        w_wr_rs_nxt     = r_wr_rs;
        w_wr_start_nxt  = 1'b0;
        case (r_state)
            ST_PWRUP: begin
                if (w_tc) begin
                    w_state_nxt = ST_ISSUE;
                    w_mode_nxt  = MODE_INIT;
                    w_step_nxt  = 6'd0;
                end
            end
            ST_ISSUE: begin
                w_wr_start_nxt = 1'b1;
                w_state_nxt    = ST_WAIT;
                if (r_mode == MODE_INIT) begin
                    w_wr_data_nxt = init_byte(r_step);
                    w_wr_rs_nxt   = 1'b0;
                end else if (r_step == 6'd0) begin
                    w_wr_data_nxt = CMD_LINE1;
                    w_wr_rs_nxt   = 1'b0;
                end else if (r_step == LINE2_STEP) begin
                    w_wr_data_nxt = CMD_LINE2;
                    w_wr_rs_nxt   = 1'b0;
                end else begin
                    w_wr_data_nxt = i_char_data;
                    w_wr_rs_nxt   = 1'b1;
                end
            end
            ST_WAIT: begin
                if (i_wr_done) begin
                    w_state_nxt = ST_GAP;
                end else if (w_tc) begin
                    // Timeout drops the sequence and any request queued behind it.
                    w_err_nxt     = 1'b1;
                    w_pending_nxt = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (w_tc) begin
                    if (!w_last_step) begin
                        w_step_nxt  = r_step + 6'd1;
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        if (r_mode == MODE_INIT) begin
                            w_init_done_nxt = 1'b1;
                        end
                        if (r_pending || i_refresh_req) begin
                            w_state_nxt   = ST_ISSUE;
                            w_mode_nxt    = MODE_REFRESH;
                            w_step_nxt    = 6'd0;
                            w_pending_nxt = 1'b0;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            ST_IDLE: begin
                if (i_refresh_req && r_init_done && !r_pending) begin
                    w_state_nxt   = ST_ISSUE;
                    w_mode_nxt    = MODE_REFRESH;
                    w_step_nxt    = 6'd0;
                    w_pending_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_PWRUP;
            r_mode      <= MODE_INIT;
            r_step      <= 6'd0;
            r_pending   <= 1'b0;
            r_init_done <= 1'b0;
            r_err       <= 1'b0;
            r_wr_data   <= 8'h00;
            r_wr_rs     <= 1'b0;
            r_wr_start  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mode      <= w_mode_nxt;
            r_step      <= w_step_nxt;
            r_pending   <= w_pending_nxt;
            r_init_done <= w_init_done_nxt;
            r_err       <= w_err_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_wr_rs     <= w_wr_rs_nxt;
            r_wr_start  <= w_wr_start_nxt;
        end
    end

    assign o_char_addr = (r_mode == MODE_REFRESH) ? refresh_addr(r_step) : 5'd0;
    assign o_wr_data   = r_wr_data;
    assign o_wr_rs     = r_wr_rs;
    assign o_wr_start  = r_wr_start;
    assign o_init_done = r_init_done;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_err       = r_err;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Self-checking bench for lcd_sequencer: writer model with programmable withholding,
// byte-list reference model built from the command/buffer rules.
module tb_lcd_sequencer;

    localparam int PWR = 20;
    localparam int GAP = 4;
    localparam int CLR = 10;
    localparam int TMO = 16;
    localparam int WR_LAT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       refresh_req = 1'b0;
    logic [4:0] char_addr;
    logic [7:0] char_data;
    logic [7:0] wr_data;
    logic       wr_rs;
    logic       wr_start;
    logic       wr_done;
    logic       init_done;
    logic       busy;
    logic       err;

    logic [7:0] buffer [32];
    logic       wdone = 1'b0;
    logic       spur = 1'b0;
    logic       withhold = 1'b0;

    assign char_data = buffer[char_addr];
    assign wr_done   = wdone | spur;

    lcd_sequencer #(
        .POWERUP_CYC (20'(PWR)),
        .GAP_CYC     (20'(GAP)),
        .CLR_CYC     (20'(CLR)),
        .TIMEOUT_CYC (20'(TMO))
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_refresh_req (refresh_req),
        .o_char_addr   (char_addr),
        .i_char_data   (char_data),
        .o_wr_data     (wr_data),
        .o_wr_rs       (wr_rs),
        .o_wr_start    (wr_start),
        .i_wr_done     (wr_done),
        .o_init_done   (init_done),
        .o_busy        (busy),
        .o_err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] data;
        logic       rs;
        int         cyc;
    } rec_t;

    typedef struct {
        logic [7:0] data;
        logic       rs;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       rs;
        int         next_ivl;
    } init_vec_t;

    rec_t      got_q [$];
    exp_t      exp_q [$];
    init_vec_t init_tab [4];

    int n_checks = 0;
    int n_fail = 0;
    int unstable = 0;
    int init_cyc = -1;
    int rel_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Writer model and transfer monitor, sampled on the falling edge.
    initial begin
        int   wcnt;
        logic active;
        logic [7:0] cap_d;
        logic cap_rs;
        wcnt = 0;
        active = 1'b0;
        cap_d = 8'h00;
        cap_rs = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wcnt = 0;
                wdone = 1'b0;
                active = 1'b0;
                init_cyc = -1;
            end else begin
                wdone = 1'b0;
                if (wcnt > 0) begin
                    wcnt--;
                    if (wcnt == 0 && !withhold) wdone = 1'b1;
                end
                if (active && !wr_start && (wr_data !== cap_d || wr_rs !== cap_rs)) unstable++;
                if (wdone) active = 1'b0;
                if (wr_start) begin
                    got_q.push_back('{data: wr_data, rs: wr_rs, cyc: cyc});
                    cap_d = wr_data;
                    cap_rs = wr_rs;
                    active = 1'b1;
                    wcnt = WR_LAT;
                end
                if (init_done && init_cyc < 0) init_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic pulse_req(output int at_cyc);
        tick();
        refresh_req = 1'b1;
        at_cyc = cyc;
        tick();
        refresh_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int fall_cyc);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        fall_cyc = cyc;
        check("reach_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_starts(input int count, input int budget);
        int n;
        n = 0;
        while (got_q.size() < count && n < budget) begin
            tick();
            n++;
        end
        check("start_seen", (got_q.size() >= count) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic do_release();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rel_cyc = cyc;
    endtask

    function automatic void push_init();
        for (int i = 0; i < 4; i++) exp_q.push_back('{data: init_tab[i].data, rs: 1'b0});
    endfunction

    function automatic void push_refresh();
        exp_q.push_back('{data: 8'h80, rs: 1'b0});
        for (int i = 0; i < 16; i++) exp_q.push_back('{data: buffer[i], rs: 1'b1});
        exp_q.push_back('{data: 8'hC0, rs: 1'b0});
        for (int i = 16; i < 32; i++) exp_q.push_back('{data: buffer[i], rs: 1'b1});
    endfunction

    task automatic compare_seq(input string name);
        int n;
        check({name, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", name, i), {23'd0, got_q[i].rs, got_q[i].data},
                  {23'd0, exp_q[i].rs, exp_q[i].data});
        end
        check({name, "_stable"}, unstable, 0);
        got_q.delete();
        exp_q.delete();
        unstable = 0;
    endtask

    initial begin
        int t0;
        int fall;
        int rq;
        int n0;

        init_tab[0] = '{data: 8'h38, rs: 1'b0, next_ivl: WR_LAT + 1 + GAP + 1};
        init_tab[1] = '{data: 8'h0C, rs: 1'b0, next_ivl: WR_LAT + 1 + GAP + 1};
        init_tab[2] = '{data: 8'h01, rs: 1'b0, next_ivl: WR_LAT + 1 + CLR + 1};
        init_tab[3] = '{data: 8'h06, rs: 1'b0, next_ivl: WR_LAT + 1 + GAP};
        for (int i = 0; i < 32; i++) buffer[i] = 8'(8'h41 + i);

        // Reset values
        repeat (3) tick();
        check("rst_wr_start", {31'd0, wr_start}, 0);
        check("rst_wr_data", {24'd0, wr_data}, 0);
        check("rst_wr_rs", {31'd0, wr_rs}, 0);
        check("rst_char_addr", {27'd0, char_addr}, 0);
        check("rst_init_done", {31'd0, init_done}, 0);
        check("rst_busy", {31'd0, busy}, 1);
        check("rst_err", {31'd0, err}, 0);
        do_release();

        // Init sequence: bytes, start spacing, init_done/busy timing
        wait_idle(500, fall);
        check("init_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            check("init_first_start", got_q[0].cyc - rel_cyc, PWR + 1);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("init_byte%0d", i), {23'd0, got_q[i].rs, got_q[i].data},
                      {23'd0, init_tab[i].rs, init_tab[i].data});
                if (i < 3) check($sformatf("init_ivl%0d", i), got_q[i + 1].cyc - got_q[i].cyc,
                                 init_tab[i].next_ivl);
            end
            check("init_done_time", init_cyc - got_q[3].cyc, init_tab[3].next_ivl);
            check("busy_fall_time", fall, init_cyc);
        end
        check("init_stable", unstable, 0);
        got_q.delete();
        unstable = 0;

        // HELLO refresh with 2-cycle request latency
        pulse_req(rq);
        wait_idle(1000, fall);
        if (got_q.size() > 0) check("req_latency", got_q[0].cyc - rq, 2);
        push_refresh();
        compare_seq("hello");

        // Request during init: exactly one refresh follows init
        for (int i = 0; i < 32; i++) buffer[i] = 8'($urandom);
        tick();
        rst_n = 1'b0;
        repeat (2) tick();
        do_release();
        repeat ($urandom_range(55, 2)) tick();
        pulse_req(rq);
        wait_idle(1500, fall);
        push_init();
        push_refresh();
        compare_seq("init_pend");
        check("init_pend_done", {31'd0, init_done}, 1);

        // Two requests during a refresh merge into one extra refresh
        for (int i = 0; i < 32; i++) buffer[i] = 8'($urandom);
        pulse_req(rq);
        repeat ($urandom_range(120, 5)) tick();
        pulse_req(rq);
        repeat ($urandom_range(120, 5)) tick();
        pulse_req(rq);
        wait_idle(2000, fall);
        push_refresh();
        push_refresh();
        compare_seq("merge");

        // Spurious done in GAP must not disturb the sequence
        pulse_req(rq);
        wait_starts(1, 50);
        t0 = (got_q.size() > 0) ? got_q[0].cyc : cyc;
        while (cyc < t0 + 5) tick();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        wait_idle(1000, fall);
        if (got_q.size() > 1) check("gap_spur_ivl", got_q[1].cyc - got_q[0].cyc,
                                    WR_LAT + 1 + GAP + 1);
        push_refresh();
        compare_seq("gap_spur");

        // Spurious done in IDLE
        spur = 1'b1;
        tick();
        spur = 1'b0;
        repeat (30) tick();
        check("idle_spur_starts", got_q.size(), 0);
        check("idle_spur_busy", {31'd0, busy}, 0);

        // Timeout: err exactly TMO cycles after start; queued request discarded
        withhold = 1'b1;
        pulse_req(rq);
        wait_starts(1, 50);
        t0 = (got_q.size() > 0) ? got_q[0].cyc : cyc;
        while (cyc < t0 + 5) tick();
        pulse_req(rq);
        while (cyc < t0 + TMO - 1) tick();
        check("err_before_tmo", {31'd0, err}, 0);
        tick();
        check("err_at_tmo", {31'd0, err}, 1);
        check("busy_at_tmo", {31'd0, busy}, 0);
        withhold = 1'b0;
        repeat (40) tick();
        check("tmo_discard_starts", got_q.size(), 1);
        check("tmo_idle", {31'd0, busy}, 0);
        got_q.delete();
        unstable = 0;
        pulse_req(rq);
        wait_idle(1000, fall);
        push_refresh();
        compare_seq("post_err");
        check("err_sticky", {31'd0, err}, 1);

        // Reset in the middle of a refresh at step 10
        pulse_req(rq);
        wait_starts(11, 400);
        n0 = got_q.size();
        check("mid_step10_data", (n0 >= 11) ? {24'd0, got_q[10].data} : 32'hFFFF,
              {24'd0, buffer[9]});
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_start", {31'd0, wr_start}, 0);
        check("mid_rst_init_done", {31'd0, init_done}, 0);
        check("mid_rst_busy", {31'd0, busy}, 1);
        check("mid_rst_err", {31'd0, err}, 0);
        got_q.delete();
        exp_q.delete();
        unstable = 0;
        repeat (2) tick();
        do_release();
        wait_idle(500, fall);
        if (got_q.size() > 0) check("reinit_first_start", got_q[0].cyc - rel_cyc, PWR + 1);
        push_init();
        compare_seq("reinit");
        check("reinit_done", {31'd0, init_done}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "global timeout");
    end

endmodule
